// File: rtl/fsm_automatic_garage_door_controller.sv
// Garage-door motor controller: three-state Moore FSM driven by a request level and
// two travel-limit switches. Motor outputs decode from the state register only.
module fsm_automatic_garage_door_controller (
  input  logic CLK,
  input  logic RST,
  input  logic Active,
  input  logic UP_Max,
  input  logic DN_Max,
  output logic Up_Motor,
  output logic Down_Motor
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMvUp = 2'b01,
    StMvDn = 2'b10
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle: begin
        if (Active && DN_Max && !UP_Max) begin
          state_d = StMvUp;
        end else if (Active && UP_Max && !DN_Max) begin
          state_d = StMvDn;
        end else begin
          state_d = StIdle;
        end
      end
      StMvUp: state_d = (UP_Max || !Active) ? StIdle : StMvUp;
      StMvDn: state_d = (DN_Max || !Active) ? StIdle : StMvDn;
      // Unused encoding 2'b11 recovers to idle on the next edge.
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Up_Motor   = 1'b0;
    Down_Motor = 1'b0;
    unique case (state_q)
      StMvUp:  Up_Motor   = 1'b1;
      StMvDn:  Down_Motor = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_automatic_garage_door_controller.sv
// Directed bench for the garage-door controller; expected motor pairs are hand-derived
// from the transition table, written as {Up_Motor, Down_Motor}.
module tb_fsm_automatic_garage_door_controller;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Active = 1'b0;
  logic UP_Max = 1'b0;
  logic DN_Max = 1'b0;
  logic Up_Motor;
  logic Down_Motor;

  int n_cmp  = 0;
  int n_fail = 0;

  fsm_automatic_garage_door_controller dut (
    .CLK        (CLK),
    .RST        (RST),
    .Active     (Active),
    .UP_Max     (UP_Max),
    .DN_Max     (DN_Max),
    .Up_Motor   (Up_Motor),
    .Down_Motor (Down_Motor)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic a, input logic u, input logic d);
    @(negedge CLK);
    Active = a;
    UP_Max = u;
    DN_Max = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #2;
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 00", {Up_Motor, Down_Motor});
    end
    @(negedge CLK);
    RST = 1'b1;
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 00", {Up_Motor, Down_Motor});
    end
  endtask

  task automatic test_open_release();
    drive(1'b1, 1'b0, 1'b1);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b10) begin
      n_fail++;
      $display("FAIL open_start: got %b want 10", {Up_Motor, Down_Motor});
    end
    // Mid-travel with request held keeps the motor running.
    drive(1'b1, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b10) begin
      n_fail++;
      $display("FAIL open_hold: got %b want 10", {Up_Motor, Down_Motor});
    end
    drive(1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL open_release: got %b want 00", {Up_Motor, Down_Motor});
    end
  endtask

  task automatic test_close_limit();
    drive(1'b1, 1'b1, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b01) begin
      n_fail++;
      $display("FAIL close_start: got %b want 01", {Up_Motor, Down_Motor});
    end
    drive(1'b1, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b01) begin
      n_fail++;
      $display("FAIL close_hold: got %b want 01", {Up_Motor, Down_Motor});
    end
    drive(1'b1, 1'b0, 1'b1);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL close_limit: got %b want 00", {Up_Motor, Down_Motor});
    end
    // Released while closing also stops.
    drive(1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL close_release: got %b want 00", {Up_Motor, Down_Motor});
    end
  endtask

  task automatic test_no_start();
    logic [2:0] pats [3];
    pats[0] = 3'b011;
    pats[1] = 3'b111;
    pats[2] = 3'b100;
    for (int p = 0; p < 3; p++) begin
      drive(pats[p][2], pats[p][1], pats[p][0]);
      for (int k = 0; k < 3; k++) begin
        step();
        n_cmp++;
        if ({Up_Motor, Down_Motor} !== 2'b00) begin
          n_fail++;
          $display("FAIL no_start pat=%b edge=%0d: got %b want 00", pats[p], k,
                   {Up_Motor, Down_Motor});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b10) begin
      n_fail++;
      $display("FAIL rev_up: got %b want 10", {Up_Motor, Down_Motor});
    end
    drive(1'b1, 1'b1, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL rev_idle: got %b want 00", {Up_Motor, Down_Motor});
    end
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b01) begin
      n_fail++;
      $display("FAIL rev_down: got %b want 01", {Up_Motor, Down_Motor});
    end
    // Sensor fault while moving: own stop limit is high, so exit to idle.
    drive(1'b1, 1'b1, 1'b1);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL fault_from_dn: got %b want 00", {Up_Motor, Down_Motor});
    end
    drive(1'b1, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b1);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL fault_from_up: got %b want 00", {Up_Motor, Down_Motor});
    end
  endtask

  task automatic test_reset_mid_motion();
    drive(1'b1, 1'b1, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_pre: got %b want 01", {Up_Motor, Down_Motor});
    end
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_async_mid: got %b want 00", {Up_Motor, Down_Motor});
    end
    // Release with a mid-travel request: not a valid start, stays idle.
    drive(1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if ({Up_Motor, Down_Motor} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_after edge=%0d: got %b want 00", k, {Up_Motor, Down_Motor});
      end
    end
    drive(1'b1, 1'b1, 1'b0);
    step();
    n_cmp++;
    if ({Up_Motor, Down_Motor} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_restart: got %b want 01", {Up_Motor, Down_Motor});
    end
  endtask

  initial begin
    test_reset();
    test_open_release();
    test_close_limit();
    test_no_start();
    test_back_to_back();
    test_reset_mid_motion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
